// File: rtl/sprite_bus_pkg.sv
// rtl/sprite_bus_pkg.sv - shared types and encodings for the sprite bus initiator
package sprite_bus_pkg;

  localparam logic [1:0] SZ_8     = 2'b00;
  localparam logic [1:0] SZ_16    = 2'b01;
  localparam logic [1:0] SZ_32    = 2'b10;
  localparam logic [1:0] SZ_BAD   = 2'b11;
  localparam logic [1:0] BUS_IDLE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WIN,
    WRITE,
    READ,
    RESP
  } state_e;

  typedef struct packed {
    logic        read;
    logic [1:0]  size;
    logic [5:0]  addr;
    logic [31:0] data;
  } cmd_t;

  function automatic logic [31:0] zero_extend(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_8:    return {24'b0, d[7:0]};
      SZ_16:   return {16'b0, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous command FIFO with full/empty flags
module cmd_fifo
  import sprite_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic push_i,
  input  cmd_t push_data_i,
  input  logic pop_i,
  output cmd_t pop_data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count says they were written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/sprite_bus_initiator.sv
// rtl/sprite_bus_initiator.sv - queues register commands and replays them onto the peripheral bus
module sprite_bus_initiator
  import sprite_bus_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_read_i,
  input  logic [1:0]  cmd_size_i,
  input  logic [5:0]  cmd_addr_i,
  input  logic [31:0] cmd_data_i,
  input  logic        gate_en_i,
  input  logic        vsync_i,
  output logic [5:0]  bus_address_o,
  output logic [31:0] bus_wdata_o,
  output logic [1:0]  bus_write_n_o,
  output logic [1:0]  bus_read_n_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ready_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        timeout_err_o,
  input  logic        err_clr_i
);

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  state_e      state_q, state_d;
  logic [1:0]  write_n_q, write_n_d;
  logic [1:0]  read_n_q, read_n_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        timeout_err_q, timeout_err_d;
  logic        launch;

  cmd_t fifo_head;
  cmd_t fifo_in;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_push;

  // Illegal sizes complete the handshake but never enter the queue.
  assign fifo_push = cmd_valid_i && !fifo_full && (cmd_size_i != SZ_BAD);
  assign fifo_in   = '{read: cmd_read_i, size: cmd_size_i, addr: cmd_addr_i, data: cmd_data_i};

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (fifo_push),
    .push_data_i (fifo_in),
    .pop_i       (launch),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign cmd_ready_o   = !fifo_full;
  assign busy_o        = !fifo_empty || (state_q != IDLE);
  assign bus_address_o = addr_q;
  assign bus_wdata_o   = wdata_q;
  assign bus_write_n_o = write_n_q;
  assign bus_read_n_o  = read_n_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_data_o    = rsp_data_q;
  assign timeout_err_o = timeout_err_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      write_n_q     <= BUS_IDLE;
      read_n_q      <= BUS_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_data_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_n_q     <= write_n_d;
      read_n_q      <= read_n_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_data_q    <= rsp_data_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    write_n_d     = write_n_q;
    read_n_d      = read_n_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_err_d     = rsp_err_q;
    rsp_data_d    = rsp_data_q;
    timeout_err_d = timeout_err_q && !err_clr_i;
    launch        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (gate_en_i && !vsync_i) state_d = WAIT_WIN;
          else                       launch  = 1'b1;
        end
      end
      WAIT_WIN: begin
        if (vsync_i || !gate_en_i) launch = 1'b1;
      end
      WRITE: begin
        write_n_d = BUS_IDLE;
        state_d   = IDLE;
      end
      READ: begin
        if (bus_ready_i) begin
          read_n_d    = BUS_IDLE;
          rsp_data_d  = zero_extend(read_n_q, bus_rdata_i);
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cnt_q == TIMEOUT_CNT) begin
          // Timeout set is placed after the err_clr default so a same-cycle clear loses.
          read_n_d      = BUS_IDLE;
          rsp_data_d    = '0;
          rsp_err_d     = 1'b1;
          rsp_valid_d   = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      addr_d = fifo_head.addr;
      cnt_d  = '0;
      if (fifo_head.read) begin
        read_n_d = fifo_head.size;
        state_d  = READ;
      end else begin
        wdata_d   = fifo_head.data;
        write_n_d = fifo_head.size;
        state_d   = WRITE;
      end
    end
  end

endmodule

// File: tb/tb_sprite_bus_initiator.sv
// tb/tb_sprite_bus_initiator.sv - directed scoreboard bench for sprite_bus_initiator
module tb_sprite_bus_initiator;

  typedef struct packed {
    logic [1:0]  wn;
    logic [1:0]  rn;
    logic [5:0]  addr;
    logic [31:0] wd;
  } bus_ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_read = 1'b0;
  logic [1:0]  cmd_size = 2'b00;
  logic [5:0]  cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        gate_en = 1'b0;
  logic        vsync = 1'b0;
  logic [5:0]  bus_address;
  logic [31:0] bus_wdata;
  logic [1:0]  bus_write_n;
  logic [1:0]  bus_read_n;
  logic [31:0] bus_rdata = '0;
  logic        bus_ready = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        timeout_err;
  logic        err_clr = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_strobes = 0;
  int last_strobe_cyc = 0;
  int push_cyc = 0;
  int s, s_cyc;
  int strobe_cyc[$];
  bus_ev_t exp_bus[$];
  logic [32:0] exp_rsp[$];
  logic [1:0] prev_wn = 2'b11;
  logic [1:0] prev_rn = 2'b11;

  always #5 clk = ~clk;

  sprite_bus_initiator #(.DEPTH(4), .TIMEOUT(255)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_read_i    (cmd_read),
    .cmd_size_i    (cmd_size),
    .cmd_addr_i    (cmd_addr),
    .cmd_data_i    (cmd_data),
    .gate_en_i     (gate_en),
    .vsync_i       (vsync),
    .bus_address_o (bus_address),
    .bus_wdata_o   (bus_wdata),
    .bus_write_n_o (bus_write_n),
    .bus_read_n_o  (bus_read_n),
    .bus_rdata_i   (bus_rdata),
    .bus_ready_i   (bus_ready),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_data_o    (rsp_data),
    .rsp_err_o     (rsp_err),
    .busy_o        (busy),
    .timeout_err_o (timeout_err),
    .err_clr_i     (err_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bus_ev_t e;
    logic [32:0] r;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      chk("rsp_expected", exp_rsp.size() != 0, 1'b1);
      if (exp_rsp.size() != 0) begin
        r = exp_rsp.pop_front();
        chk("rsp", {rsp_err, rsp_data}, r);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (prev_wn !== 2'b11) chk("wr_one_cycle", bus_write_n, 2'b11);
    if ((bus_write_n !== 2'b11 && prev_wn === 2'b11) || (bus_read_n !== 2'b11 && prev_rn === 2'b11)) begin
      n_strobes++;
      last_strobe_cyc = cyc;
      strobe_cyc.push_back(cyc);
      chk("strobe_expected", exp_bus.size() != 0, 1'b1);
      if (exp_bus.size() != 0) begin
        e = exp_bus.pop_front();
        chk("strobe", {bus_write_n, bus_read_n, bus_address}, {e.wn, e.rn, e.addr});
        if (e.rn == 2'b11) chk("wdata", bus_wdata, e.wd);
      end
    end
    prev_wn = bus_write_n;
    prev_rn = bus_read_n;
  endtask

  task automatic push(input logic rd, input logic [1:0] sz, input logic [5:0] a, input logic [31:0] d);
    bus_ev_t e;
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_size  = sz;
    cmd_addr  = a;
    cmd_data  = d;
    chk("push_ready", cmd_ready, 1'b1);
    if (sz != 2'b11) begin
      e.wn   = rd ? 2'b11 : sz;
      e.rn   = rd ? sz : 2'b11;
      e.addr = a;
      e.wd   = d;
      exp_bus.push_back(e);
    end
    tick();
    cmd_valid = 1'b0;
    push_cyc  = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", {bus_write_n, bus_read_n}, 4'hF);
    chk("rst_addr", bus_address, 6'h00);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 34'h0);
    chk("rst_flags", {busy, timeout_err, cmd_ready}, 3'b001);
    reset = 1'b0;

    // Single ungated write
    push(1'b0, 2'b10, 6'h04, 32'h12345678);
    chk("busy_pending", busy, 1'b1);
    tick();
    chk("wr_latency", last_strobe_cyc, push_cyc + 1);
    chk("wr_strobe", bus_write_n, 2'b10);
    tick();
    chk("busy_after_wr", busy, 1'b0);
    chk("addr_hold", {bus_address, bus_wdata}, {6'h04, 32'h12345678});

    // 8-bit read, ready three cycles into the strobe
    bus_rdata = 32'hAABBCCDD;
    exp_rsp.push_back({1'b0, 32'h000000DD});
    push(1'b1, 2'b00, 6'h08, 32'h0);
    tick();
    chk("rd_latency", last_strobe_cyc, push_cyc + 1);
    repeat (3) tick();
    chk("rd_held", {bus_read_n, rsp_valid}, {2'b00, 1'b0});
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    chk("rd_release", bus_read_n, 2'b11);
    chk("rd_rsp", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b0, 32'h000000DD});
    repeat (3) tick();
    chk("rsp_hold", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 1'b0);
    chk("rsp_drained", exp_rsp.size(), 0);

    // Illegal size is swallowed
    push(1'b0, 2'b11, 6'h3F, 32'hDEADBEEF);
    s = n_strobes;
    repeat (4) tick();
    chk("illegal_no_strobe", n_strobes, s);
    chk("illegal_busy", busy, 1'b0);

    // Gated writes released by vsync
    gate_en = 1'b1;
    vsync   = 1'b0;
    push(1'b0, 2'b00, 6'h10, 32'h000000A1);
    push(1'b0, 2'b01, 6'h11, 32'h0000B2B2);
    push(1'b0, 2'b10, 6'h12, 32'hC3C3C3C3);
    s = n_strobes;
    repeat (4) tick();
    chk("gated_no_strobe", n_strobes, s);
    chk("gated_busy", busy, 1'b1);
    strobe_cyc.delete();
    vsync = 1'b1;
    for (int i = 0; i < 20 && n_strobes < s + 3; i++) tick();
    chk("gated_count", n_strobes, s + 3);
    if (strobe_cyc.size() == 3) begin
      chk("gap1", strobe_cyc[1] - strobe_cyc[0], 2);
      chk("gap2", strobe_cyc[2] - strobe_cyc[1], 2);
    end
    repeat (2) tick();
    vsync   = 1'b0;
    gate_en = 1'b0;
    chk("gated_done", busy, 1'b0);

    // Read that never sees ready
    exp_rsp.push_back({1'b1, 32'h0});
    push(1'b1, 2'b10, 6'h20, 32'h0);
    tick();
    s_cyc = last_strobe_cyc;
    chk("to_strobe", bus_read_n, 2'b10);
    for (int i = 0; i < 400 && bus_read_n !== 2'b11; i++) tick();
    chk("timeout_len", cyc - s_cyc, 256);
    chk("to_rsp", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b1, 32'h0});
    chk("to_sticky", timeout_err, 1'b1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    repeat (3) tick();
    chk("to_sticky_hold", timeout_err, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_cleared", timeout_err, 1'b0);
    chk("bus_drained", exp_bus.size(), 0);
    chk("rsp_drained2", exp_rsp.size(), 0);

    // Fill while gated, then reset mid-read
    gate_en = 1'b1;
    vsync   = 1'b0;
    push(1'b1, 2'b10, 6'h30, 32'h0);
    push(1'b0, 2'b10, 6'h31, 32'h11111111);
    push(1'b0, 2'b10, 6'h32, 32'h22222222);
    chk("ready_before_full", cmd_ready, 1'b1);
    push(1'b0, 2'b10, 6'h33, 32'h33333333);
    chk("ready_full", cmd_ready, 1'b0);
    cmd_valid = 1'b1;
    cmd_addr  = 6'h34;
    tick();
    cmd_valid = 1'b0;
    chk("full_hold", cmd_ready, 1'b0);
    vsync = 1'b1;
    for (int i = 0; i < 10 && bus_read_n === 2'b11; i++) tick();
    chk("rd5_started", bus_read_n, 2'b10);
    repeat (2) tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_strobes", {bus_write_n, bus_read_n}, 4'hF);
    chk("rst_mid_fifo", {cmd_ready, busy, rsp_valid}, 3'b100);
    vsync   = 1'b0;
    gate_en = 1'b0;
    exp_bus.delete();
    prev_wn = 2'b11;
    prev_rn = 2'b11;
    @(posedge clk);
    #1;
    reset = 1'b0;
    s = n_strobes;
    repeat (4) tick();
    chk("flush_no_strobe", n_strobes, s);
    chk("flush_idle", {busy, cmd_ready}, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
